// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: allocates note events onto shared voices and mixes
// one saturated, velocity-scaled audio sample per sample period.
module poly_voice_engine #(
  parameter int NUM_VOICES    = 16,
  parameter int AUDIO_WIDTH   = 24,
  parameter int PHASE_WIDTH   = 32,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic                          note_on,
  input  logic [6:0]                    note_num,
  input  logic [6:0]                    note_vel,
  input  logic [PHASE_WIDTH-1:0]        note_incr,
  input  logic [1:0]                    wave_type,
  output logic signed [AUDIO_WIDTH-1:0] audio_out,
  output logic                          audio_valid,
  output logic [NUM_VOICES-1:0]         voice_active
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = AUDIO_WIDTH + IDX_W + 1;
  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ALLOC, RENDER, OUTPUT} state_t;

  state_t                        r_state, w_nextState;
  logic [CNT_W-1:0]              r_sampleCnt;
  logic                          r_tickPending, r_noteReady;
  logic                          w_wrap, w_nextPending, w_accept;

  logic [NUM_VOICES-1:0]         r_active;
  logic [6:0]                    r_note  [NUM_VOICES];
  logic [6:0]                    r_vel   [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]        r_incr  [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]        r_phase [NUM_VOICES];
  logic [7:0]                    r_age   [NUM_VOICES];

  logic                          r_evOn;
  logic [6:0]                    r_evNum, r_evVel;
  logic [PHASE_WIDTH-1:0]        r_evIncr;
  logic [1:0]                    r_wave;
  logic [IDX_W-1:0]              r_voiceIdx;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [AUDIO_WIDTH-1:0] r_audioOut, w_satOut;
  logic                          r_audioValid;

  logic                          w_matchHit, w_freeHit;
  logic [IDX_W-1:0]              w_matchIdx, w_freeIdx, w_oldIdx, w_target;
  logic [7:0]                    w_oldAge;
  logic [15:0]                   w_phTop, w_sample;
  logic [14:0]                   w_tri;
  logic [7:0]                    w_scale;
  logic [23:0]                   w_prod, w_contrib;
  logic signed [ACC_W-1:0]       w_contribExt;

  assign note_ready   = r_noteReady;
  assign audio_out    = r_audioOut;
  assign audio_valid  = r_audioValid;
  assign voice_active = r_active;

  assign w_wrap        = (r_sampleCnt == CNT_W'(SAMPLE_PERIOD - 1));
  assign w_nextPending = w_wrap | (r_tickPending & (r_state != IDLE));
  assign w_accept      = note_valid & r_noteReady;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_tickPending) w_nextState = RENDER;
               else if (w_accept) w_nextState = ALLOC;
      ALLOC:   w_nextState = IDLE;
      RENDER:  if (r_voiceIdx == IDX_W'(NUM_VOICES - 1)) w_nextState = OUTPUT;
      OUTPUT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Ready is registered from next-cycle state so it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_sampleCnt   <= '0;
      r_tickPending <= 1'b0;
      r_noteReady   <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_sampleCnt   <= w_wrap ? '0 : r_sampleCnt + CNT_W'(1);
      r_tickPending <= w_nextPending;
      r_noteReady   <= (w_nextState == IDLE) && !w_nextPending;
    end
  end

  always_comb begin
    w_matchHit = 1'b0;
    w_matchIdx = '0;
    w_freeHit  = 1'b0;
    w_freeIdx  = '0;
    w_oldIdx   = '0;
    w_oldAge   = r_age[0];
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_note[i] == r_evNum)) begin
        w_matchHit = 1'b1;
        w_matchIdx = IDX_W'(i);
      end
      if (!r_active[i]) begin
        w_freeHit = 1'b1;
        w_freeIdx = IDX_W'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_oldAge) begin
        w_oldAge = r_age[i];
        w_oldIdx = IDX_W'(i);
      end
    end
    w_target = w_matchHit ? w_matchIdx : (w_freeHit ? w_freeIdx : w_oldIdx);
  end

  assign w_phTop = r_phase[r_voiceIdx][PHASE_WIDTH-1 -: 16];
  assign w_tri   = w_phTop[15] ? ~w_phTop[14:0] : w_phTop[14:0];

  always_comb begin
    case (r_wave)
      2'd0:    w_sample = {~w_phTop[15], w_phTop[14:0]};
      2'd1:    w_sample = w_phTop[15] ? 16'h8001 : 16'h7FFF;
      2'd2:    w_sample = {~w_tri[14], w_tri[13:0], 1'b0};
      default: w_sample = 16'h0000;
    endcase
  end

  // Low 24 bits of an unsigned product equal the two's-complement product.
  assign w_scale      = {1'b0, r_vel[r_voiceIdx]} + 8'd1;
  assign w_prod       = {{8{w_sample[15]}}, w_sample} * {16'd0, w_scale};
  assign w_contrib    = r_active[r_voiceIdx] ? w_prod : 24'd0;
  assign w_contribExt = {{(ACC_W-24){w_contrib[23]}}, w_contrib};

  assign w_satOut = (r_acc > SAT_MAX) ? SAT_MAX[AUDIO_WIDTH-1:0] :
                    (r_acc < SAT_MIN) ? SAT_MIN[AUDIO_WIDTH-1:0] :
                                        r_acc[AUDIO_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= '0;
      r_evOn       <= 1'b0;
      r_evNum      <= '0;
      r_evVel      <= '0;
      r_evIncr     <= '0;
      r_wave       <= '0;
      r_voiceIdx   <= '0;
      r_acc        <= '0;
      r_audioOut   <= '0;
      r_audioValid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i]  <= '0;
        r_vel[i]   <= '0;
        r_incr[i]  <= '0;
        r_phase[i] <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      r_audioValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_tickPending) begin
            r_wave     <= wave_type;
            r_voiceIdx <= '0;
            r_acc      <= '0;
          end else if (w_accept) begin
            r_evOn   <= note_on;
            r_evNum  <= note_num;
            r_evVel  <= note_vel;
            r_evIncr <= note_incr;
          end
        end
        ALLOC: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_evOn) begin
              if (IDX_W'(i) == w_target) begin
                r_active[i] <= 1'b1;
                r_note[i]   <= r_evNum;
                r_vel[i]    <= r_evVel;
                r_incr[i]   <= r_evIncr;
                r_phase[i]  <= '0;
                r_age[i]    <= '0;
              end else if (r_active[i] && (r_age[i] != 8'hFF)) begin
                r_age[i] <= r_age[i] + 8'd1;
              end
            end else if (r_active[i] && (r_note[i] == r_evNum)) begin
              r_active[i] <= 1'b0;
            end
          end
        end
        RENDER: begin
          if (r_active[r_voiceIdx])
            r_phase[r_voiceIdx] <= r_phase[r_voiceIdx] + r_incr[r_voiceIdx];
          r_acc      <= r_acc + w_contribExt;
          r_voiceIdx <= r_voiceIdx + IDX_W'(1);
        end
        OUTPUT: begin
          r_audioOut   <= w_satOut;
          r_audioValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Scoreboard bench for poly_voice_engine: stimulus pushes hand-computed samples,
// an independent monitor pops and compares on every audio_valid strobe.
module tb_poly_voice_engine;

  localparam int NV  = 16;
  localparam int AW  = 24;
  localparam int PW  = 32;
  localparam int SP  = 2268;
  localparam int LAT = NV + 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 note_valid = 1'b0;
  logic                 note_ready;
  logic                 note_on = 1'b0;
  logic [6:0]           note_num = '0;
  logic [6:0]           note_vel = '0;
  logic [PW-1:0]        note_incr = '0;
  logic [1:0]           wave_type = 2'd1;
  logic signed [AW-1:0] audio_out;
  logic                 audio_valid;
  logic [NV-1:0]        voice_active;

  int     totalChecks = 0;
  int     badChecks = 0;
  int     cycleCount = 0;
  int     pulsesSeen = 0;
  int     lastPulseCycle = 0;
  int     prevPulseCycle = 0;
  longint expectQ[$];
  longint expVal;

  poly_voice_engine #(
    .NUM_VOICES(NV), .AUDIO_WIDTH(AW), .PHASE_WIDTH(PW), .SAMPLE_PERIOD(SP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_num(note_num), .note_vel(note_vel),
    .note_incr(note_incr), .wave_type(wave_type), .audio_out(audio_out),
    .audio_valid(audio_valid), .voice_active(voice_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (audio_valid) begin
      prevPulseCycle = lastPulseCycle;
      lastPulseCycle = cycleCount;
      pulsesSeen++;
      if (expectQ.size() == 0) begin
        checkOutput("unexpectedSample", 1, 0);
      end else begin
        expVal = expectQ.pop_front();
        checkOutput("audioOut", audio_out, expVal);
      end
    end
  end

  task automatic pushExp(input longint v);
    expectQ.push_back(v);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    note_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic on, input logic [6:0] num,
                               input logic [6:0] vel, input logic [PW-1:0] incr);
    int waited;
    note_valid = 1'b1;
    note_on    = on;
    note_num   = num;
    note_vel   = vel;
    note_incr  = incr;
    waited = 0;
    while (!note_ready && waited < SP + 100) begin
      @(negedge clk);
      waited++;
    end
    if (!note_ready) begin
      checkOutput("handshakeTimeout", 0, 1);
      note_valid = 1'b0;
      return;
    end
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitSamples(input int n);
    int target;
    int budget;
    target = pulsesSeen + n;
    budget = 0;
    while (pulsesSeen < target && budget < (n + 1) * SP + 200) begin
      @(negedge clk);
      budget++;
    end
    if (pulsesSeen < target) checkOutput("sampleTimeout", pulsesSeen, target);
  endtask

  task automatic waitUntilCycle(input int target);
    while (cycleCount < target) @(negedge clk);
  endtask

  initial begin
    int releaseCycle;
    int tickCycle;
    int pulsesBefore;

    // Reset state and idle sample cadence
    repeat (2) @(negedge clk);
    checkOutput("resetReady", note_ready, 0);
    checkOutput("resetValid", audio_valid, 0);
    checkOutput("resetActive", voice_active, 0);
    checkOutput("resetAudio", audio_out, 0);
    rst_n = 1'b1;
    releaseCycle = cycleCount;
    checkOutput("readyBeforeEdge", note_ready, 0);
    @(negedge clk);
    checkOutput("readyAfterReset", note_ready, 1);
    pushExp(0); pushExp(0); pushExp(0);
    waitSamples(1);
    checkOutput("firstSampleLatency", lastPulseCycle, releaseCycle + SP + LAT);
    waitSamples(1);
    checkOutput("sampleSpacing1", lastPulseCycle - prevPulseCycle, SP);
    waitSamples(1);
    checkOutput("sampleSpacing2", lastPulseCycle - prevPulseCycle, SP);

    // Single square voice, then retrigger with a new velocity
    doReset();
    wave_type = 2'd1;
    applyStimulus(1'b1, 7'd60, 7'd127, 32'h8000_0000);
    checkOutput("oneVoiceActive", voice_active, 16'h0001);
    pushExp(4194176);
    waitSamples(1);
    applyStimulus(1'b1, 7'd60, 7'd63, 32'h8000_0000);
    checkOutput("retriggerActive", voice_active, 16'h0001);
    pushExp(2097088); pushExp(-2097088);
    waitSamples(2);

    // Two-voice sum, then a third voice drives saturation both ways
    doReset();
    applyStimulus(1'b1, 7'd60, 7'd127, 32'h8000_0000);
    applyStimulus(1'b1, 7'd62, 7'd127, 32'h8000_0000);
    checkOutput("twoVoiceActive", voice_active, 16'h0003);
    pushExp(8388352); pushExp(-8388352);
    waitSamples(2);
    applyStimulus(1'b1, 7'd64, 7'd127, 32'h8000_0000);
    checkOutput("threeVoiceActive", voice_active, 16'h0007);
    pushExp(8388607); pushExp(-8388608);
    waitSamples(2);

    // Waveform shapes at quarter-cycle phase steps, velocity 1 (scale 2)
    doReset();
    wave_type = 2'd0;
    applyStimulus(1'b1, 7'd10, 7'd1, 32'h4000_0000);
    pushExp(-65536); pushExp(-32768);
    waitSamples(2);
    wave_type = 2'd2;
    pushExp(65532); pushExp(-4);
    waitSamples(2);
    wave_type = 2'd3;
    pushExp(0);
    waitSamples(1);
    wave_type = 2'd1;
    pushExp(65534);
    waitSamples(1);

    // Voice stealing: note 16 takes the oldest voice 0
    doReset();
    for (int n = 0; n < 17; n++) begin
      applyStimulus(1'b1, 7'(n), 7'd127, 32'd0);
      if (n == 15) checkOutput("allVoicesBusy", voice_active, 16'hFFFF);
    end
    checkOutput("stealKeepsFull", voice_active, 16'hFFFF);
    applyStimulus(1'b0, 7'd0, 7'd0, 32'd0);
    checkOutput("stolenNoteGone", voice_active, 16'hFFFF);
    applyStimulus(1'b0, 7'd16, 7'd0, 32'd0);
    checkOutput("stealerInVoice0", voice_active, 16'hFFFE);
    applyStimulus(1'b0, 7'd1, 7'd0, 32'd0);
    checkOutput("noteOffVoice1", voice_active, 16'hFFFC);

    // Note-off handling, including a note that matches nothing
    doReset();
    wave_type = 2'd1;
    applyStimulus(1'b1, 7'd60, 7'd127, 32'h8000_0000);
    applyStimulus(1'b1, 7'd62, 7'd127, 32'h8000_0000);
    pushExp(8388352);
    waitSamples(1);
    applyStimulus(1'b0, 7'd60, 7'd0, 32'd0);
    checkOutput("noteOff60", voice_active, 16'h0002);
    applyStimulus(1'b0, 7'd61, 7'd0, 32'd0);
    checkOutput("noteOff61NoMatch", voice_active, 16'h0002);
    pushExp(-4194176);
    waitSamples(1);
    applyStimulus(1'b0, 7'd62, 7'd0, 32'd0);
    checkOutput("allOff", voice_active, 16'h0000);
    pushExp(0);
    waitSamples(1);

    // Event colliding with a tick waits until after the sweep
    tickCycle = lastPulseCycle + SP - LAT;
    waitUntilCycle(tickCycle);
    note_valid = 1'b1;
    note_on    = 1'b1;
    note_num   = 7'd70;
    note_vel   = 7'd127;
    note_incr  = 32'd0;
    checkOutput("readyLowOnTick", note_ready, 0);
    pushExp(0);
    for (int i = 0; i < 4 * LAT && !note_ready; i++) @(negedge clk);
    checkOutput("acceptWithStrobe", audio_valid, 1);
    checkOutput("acceptCycle", cycleCount, tickCycle + LAT);
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
    checkOutput("lateEventActive", voice_active, 16'h0001);

    // Reset in the middle of the next sweep discards it
    waitUntilCycle(tickCycle + SP + 6);
    rst_n = 1'b0;
    pulsesBefore = pulsesSeen;
    @(negedge clk);
    checkOutput("midRenderResetActive", voice_active, 0);
    checkOutput("midRenderResetValid", audio_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitUntilCycle(tickCycle + SP + LAT + 40);
    checkOutput("noSampleAfterReset", pulsesSeen, pulsesBefore);
    checkOutput("scoreboardDrained", expectQ.size(), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
